// File: rtl/spike_arbiter_if.sv
// Event output channel: valid/ready handshake carrying neuron address and spike timestamp.
interface spike_arbiter_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned TS_W   = 8
);
  logic              ev_valid_o;
  logic              ev_ready_i;
  logic [ADDR_W-1:0] ev_addr_o;
  logic [TS_W-1:0]   ev_ts_o;

  modport master (
    output ev_valid_o,
    output ev_addr_o,
    output ev_ts_o,
    input  ev_ready_i
  );

  modport slave (
    input  ev_valid_o,
    input  ev_addr_o,
    input  ev_ts_o,
    output ev_ready_i
  );
endinterface

// File: rtl/spike_arbiter.sv
// Spike arbiter: timestamps per-neuron spikes, queues one per neuron, and serialises
// them onto a valid/ready channel with round-robin fairness and a saturating drop count.
module spike_arbiter #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned TS_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [N_NEURONS-1:0] spike_i,
  spike_arbiter_if.master      ev,
  output logic [7:0]           drop_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(N_NEURONS + 1);

  logic [TS_W-1:0]      ts_q, ts_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [N_NEURONS-1:0] load_vec;
  logic [TS_W-1:0]      pts_q [N_NEURONS];
  logic [ADDR_W-1:0]    rr_q, rr_d;
  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [TS_W-1:0]      evts_q, evts_d;
  logic [7:0]           drop_q, drop_d;

  logic                 slot_free;
  logic                 found;
  logic                 grant;
  logic [ADDR_W-1:0]    gidx;
  logic [CNT_W-1:0]     ndrops;
  logic [8:0]           drop_sum;

  // Round-robin search over registered pending bits, starting at rr_q.
  always_comb begin
    slot_free = !valid_q || ev.ev_ready_i;
    found     = 1'b0;
    gidx      = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      if (!found && pending_q[ADDR_W'(rr_q + ADDR_W'(k))]) begin
        found = 1'b1;
        gidx  = ADDR_W'(rr_q + ADDR_W'(k));
      end
    end
    grant = slot_free && found;
  end

  // Next-state: timestamp, pending capture/drop, output slot and drop counter.
  always_comb begin
    ts_d      = en_i ? TS_W'(ts_q + TS_W'(1)) : ts_q;
    pending_d = pending_q;
    load_vec  = '0;
    ndrops    = '0;
    rr_d      = rr_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    evts_d    = evts_q;

    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (grant && (gidx == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (en_i && spike_i[i]) begin
        if (!pending_q[i] || (grant && (gidx == ADDR_W'(i)))) begin
          pending_d[i] = 1'b1;
          load_vec[i]  = 1'b1;
        end else begin
          ndrops = CNT_W'(ndrops + CNT_W'(1));
        end
      end
    end

    if (slot_free) begin
      if (grant) begin
        valid_d = 1'b1;
        addr_d  = gidx;
        evts_d  = pts_q[gidx];
        rr_d    = ADDR_W'(gidx + ADDR_W'(1));
      end else begin
        valid_d = 1'b0;
      end
    end

    drop_sum = 9'(drop_q) + 9'(ndrops);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q      <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      evts_q    <= '0;
      drop_q    <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        pts_q[i] <= '0;
      end
    end else begin
      ts_q      <= ts_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      evts_q    <= evts_d;
      drop_q    <= drop_d;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        if (load_vec[i]) begin
          pts_q[i] <= ts_q;
        end
      end
    end
  end

  assign ev.ev_valid_o = valid_q;
  assign ev.ev_addr_o  = addr_q;
  assign ev.ev_ts_o    = evts_q;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = (|pending_q) || valid_q;

endmodule
